// File: rtl/urv_mem_arbiter_pkg.sv
// Shared definitions for urv_mem_arbiter.
//  - urv_arb_owner_e : who owns the RAM port in a given issue cycle (3-bit encoding)
//  - URV_ARB_BURST_W : width of the host burst counter
//  - urv_arb_is_cpu  : true for the owners that belong to the CPU (fetch, load, store)
package urv_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    URV_ARB_NONE   = 3'd0,
    URV_ARB_FETCH  = 3'd1,
    URV_ARB_DLOAD  = 3'd2,
    URV_ARB_DSTORE = 3'd3,
    URV_ARB_HOST   = 3'd4
  } urv_arb_owner_e;

  localparam int unsigned URV_ARB_BURST_W = 4;

  function automatic logic urv_arb_is_cpu(input urv_arb_owner_e owner);
    return (owner == URV_ARB_FETCH) || (owner == URV_ARB_DLOAD) || (owner == URV_ARB_DSTORE);
  endfunction

endpackage

// File: rtl/urv_mem_arbiter.sv
// urv_mem_arbiter: shares one single-ported synchronous RAM (1-cycle read latency) between the
// CPU instruction fetch port, the CPU data port and a host port.
//
// Ports
//  clk_i, rst_i            clock, synchronous active-high reset
//  cpu_im_*                fetch address in; instruction data and valid out
//  cpu_dm_*                load/store requests in; ready, load data, load/store done out
//  host_*                  host request/write/address/data in; grant, read data, rvalid out
//  mem_*                   RAM word address, write data, byte write enables out; read data in
//
// One owner per cycle: host > data (store > load) > fetch. The host is demoted below the CPU
// after g_host_max_burst consecutive grants taken while the CPU data port was waiting.
// Fetch is the default owner whenever nobody else wins.
module urv_mem_arbiter
  import urv_mem_arbiter_pkg::*;
#(
  parameter int unsigned g_addr_width     = 14,
  parameter int unsigned g_host_max_burst = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic [31:0]             cpu_im_addr_i,
  output logic [31:0]             cpu_im_data_o,
  output logic                    cpu_im_valid_o,

  input  logic [31:0]             cpu_dm_addr_i,
  input  logic [31:0]             cpu_dm_data_s_i,
  input  logic [3:0]              cpu_dm_data_select_i,
  input  logic                    cpu_dm_load_i,
  input  logic                    cpu_dm_store_i,
  output logic                    cpu_dm_ready_o,
  output logic [31:0]             cpu_dm_data_l_o,
  output logic                    cpu_dm_load_done_o,
  output logic                    cpu_dm_store_done_o,

  input  logic                    host_req_i,
  input  logic                    host_we_i,
  input  logic [31:0]             host_addr_i,
  input  logic [31:0]             host_wdata_i,
  output logic                    host_gnt_o,
  output logic [31:0]             host_rdata_o,
  output logic                    host_rvalid_o,

  output logic [g_addr_width-1:0] mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  output logic [3:0]              mem_bwe_o,
  input  logic [31:0]             mem_rdata_i
);

  localparam logic [URV_ARB_BURST_W-1:0] LP_BURST_MAX = URV_ARB_BURST_W'(g_host_max_burst);

  // Word addresses: upper byte-address bits are dropped, so accesses wrap around the RAM.
  logic [g_addr_width-1:0] w_im_word;
  logic [g_addr_width-1:0] w_dm_word;
  logic [g_addr_width-1:0] w_host_word;

  assign w_im_word   = cpu_im_addr_i[g_addr_width+1:2];
  assign w_dm_word   = cpu_dm_addr_i[g_addr_width+1:2];
  assign w_host_word = host_addr_i[g_addr_width+1:2];

  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{cpu_im_addr_i[31:g_addr_width+2], cpu_im_addr_i[1:0],
                                cpu_dm_addr_i[31:g_addr_width+2], cpu_dm_addr_i[1:0],
                                host_addr_i[31:g_addr_width+2], host_addr_i[1:0]};

  logic [URV_ARB_BURST_W-1:0] r_burst_cnt;
  urv_arb_owner_e             r_owner;
  logic                       r_host_rd;
  logic [g_addr_width-1:0]    r_fetch_word;

  logic           w_dm_req;
  logic           w_host_demoted;
  urv_arb_owner_e w_owner;

  assign w_dm_req       = cpu_dm_load_i | cpu_dm_store_i;
  assign w_host_demoted = (r_burst_cnt == LP_BURST_MAX);

  // Owner selection. NONE only while in reset, so nothing is issued or accepted then.
  always_comb begin
    w_owner = URV_ARB_NONE;
    if (!rst_i) begin
      if (host_req_i && !w_host_demoted) begin
        w_owner = URV_ARB_HOST;
      end else if (cpu_dm_store_i) begin
        w_owner = URV_ARB_DSTORE;
      end else if (cpu_dm_load_i) begin
        w_owner = URV_ARB_DLOAD;
      end else begin
        w_owner = URV_ARB_FETCH;
      end
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_bwe_o   = '0;
    unique case (w_owner)
      URV_ARB_HOST: begin
        mem_addr_o  = w_host_word;
        mem_wdata_o = host_wdata_i;
        mem_bwe_o   = host_we_i ? 4'hF : 4'h0;
      end
      URV_ARB_DSTORE: begin
        mem_addr_o  = w_dm_word;
        mem_wdata_o = cpu_dm_data_s_i;
        mem_bwe_o   = cpu_dm_data_select_i;
      end
      URV_ARB_DLOAD: mem_addr_o = w_dm_word;
      URV_ARB_FETCH: mem_addr_o = w_im_word;
      default: ;
    endcase
  end

  assign host_gnt_o     = (w_owner == URV_ARB_HOST);
  assign cpu_dm_ready_o = (w_owner == URV_ARB_DLOAD) || (w_owner == URV_ARB_DSTORE);

  // Host grants only count against the CPU while the data port is actually waiting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_burst_cnt <= '0;
    end else if (w_owner == URV_ARB_HOST) begin
      if (w_dm_req && (r_burst_cnt != LP_BURST_MAX)) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
    end else if (urv_arb_is_cpu(w_owner)) begin
      r_burst_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner      <= URV_ARB_NONE;
      r_host_rd    <= 1'b0;
      r_fetch_word <= '0;
    end else begin
      r_owner      <= w_owner;
      r_host_rd    <= (w_owner == URV_ARB_HOST) && !host_we_i;
      r_fetch_word <= w_im_word;
    end
  end

  // Response cycle. Gated by !rst_i so an access issued just before reset gives no pulse.
  logic w_fetch_rsp;
  logic w_load_rsp;
  logic w_host_rsp;

  assign w_fetch_rsp = !rst_i && (r_owner == URV_ARB_FETCH);
  assign w_load_rsp  = !rst_i && (r_owner == URV_ARB_DLOAD);
  assign w_host_rsp  = !rst_i && r_host_rd;

  // A branch changes the fetch address under an in-flight fetch: drop the stale word.
  assign cpu_im_valid_o      = w_fetch_rsp && (w_im_word == r_fetch_word);
  assign cpu_im_data_o       = w_fetch_rsp ? mem_rdata_i : 32'h0;
  assign cpu_dm_load_done_o  = w_load_rsp;
  assign cpu_dm_data_l_o     = w_load_rsp ? mem_rdata_i : 32'h0;
  assign cpu_dm_store_done_o = !rst_i && (r_owner == URV_ARB_DSTORE);
  assign host_rvalid_o       = w_host_rsp;
  assign host_rdata_o        = w_host_rsp ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_urv_mem_arbiter.sv
module tb_urv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] im_addr, im_data;
  logic        im_valid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_sel;
  logic        dm_load, dm_store, dm_ready, load_done, store_done;
  logic        h_req, h_we, h_gnt, h_rvalid;
  logic [31:0] h_addr, h_wdata, h_rdata;
  logic [13:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_bwe;
  logic        ram_init;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  urv_mem_arbiter dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .cpu_im_addr_i       (im_addr),
    .cpu_im_data_o       (im_data),
    .cpu_im_valid_o      (im_valid),
    .cpu_dm_addr_i       (dm_addr),
    .cpu_dm_data_s_i     (dm_wdata),
    .cpu_dm_data_select_i(dm_sel),
    .cpu_dm_load_i       (dm_load),
    .cpu_dm_store_i      (dm_store),
    .cpu_dm_ready_o      (dm_ready),
    .cpu_dm_data_l_o     (dm_rdata),
    .cpu_dm_load_done_o  (load_done),
    .cpu_dm_store_done_o (store_done),
    .host_req_i          (h_req),
    .host_we_i           (h_we),
    .host_addr_i         (h_addr),
    .host_wdata_i        (h_wdata),
    .host_gnt_o          (h_gnt),
    .host_rdata_o        (h_rdata),
    .host_rvalid_o       (h_rvalid),
    .mem_addr_o          (m_addr),
    .mem_wdata_o         (m_wdata),
    .mem_bwe_o           (m_bwe),
    .mem_rdata_i         (m_rdata)
  );

  // RAM model: 1-cycle read, read-before-write. Preloaded with 0x1000_0000|word, word 0x40 = 0x13.
  logic [31:0] ram [0:16383];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16384; i++) ram[i] <= (i == 'h40) ? 32'h13 : (32'h1000_0000 | 32'(i));
    end else begin
      for (int b = 0; b < 4; b++) if (m_bwe[b]) ram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
    end
    m_rdata <= ram[m_addr];
  end

  typedef struct {
    logic        load, store;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  sel;
    logic        hreq, hwe;
    logic [31:0] haddr, hwdata, im_addr;
    logic        e_ready, e_gnt;
    logic [13:0] e_maddr;
    logic [3:0]  e_bwe;
    logic        e_im_valid, e_load_done, e_store_done, e_rvalid;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    dm_load = 0; dm_store = 0; dm_addr = 0; dm_wdata = 0; dm_sel = 0;
    h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic build_vectors();
    vec_t idle, v;
    idle = '{load: 0, store: 0, dm_addr: 0, dm_wdata: 0, sel: 0, hreq: 0, hwe: 0, haddr: 0,
             hwdata: 0, im_addr: 32'h100, e_ready: 0, e_gnt: 0, e_maddr: 14'h40, e_bwe: 0,
             e_im_valid: 1, e_load_done: 0, e_store_done: 0, e_rvalid: 0, e_data: 32'h13};
    vecs.push_back(idle);
    // load 0x204 -> word 0x81
    v = idle; v.load = 1; v.dm_addr = 32'h204; v.e_ready = 1; v.e_maddr = 14'h81;
    v.e_im_valid = 0; v.e_load_done = 1; v.e_data = 32'h1000_0081; vecs.push_back(v);
    // store byte 1 of word 2
    v = idle; v.store = 1; v.dm_addr = 32'h8; v.dm_wdata = 32'hAABB_CCDD; v.sel = 4'b0010;
    v.e_ready = 1; v.e_maddr = 14'h2; v.e_bwe = 4'b0010; v.e_im_valid = 0;
    v.e_store_done = 1; v.e_data = 0; vecs.push_back(v);
    // read back word 2: only byte 1 replaced by 0xCC
    v = idle; v.load = 1; v.dm_addr = 32'h8; v.e_ready = 1; v.e_maddr = 14'h2;
    v.e_im_valid = 0; v.e_load_done = 1; v.e_data = 32'h1000_CC02; vecs.push_back(v);
    // host read 0x300 -> word 0xC0
    v = idle; v.hreq = 1; v.haddr = 32'h300; v.e_gnt = 1; v.e_maddr = 14'hC0;
    v.e_im_valid = 0; v.e_rvalid = 1; v.e_data = 32'h1000_00C0; vecs.push_back(v);
    // host write 0x40C -> word 0x103, all bytes, no rvalid
    v = idle; v.hreq = 1; v.hwe = 1; v.haddr = 32'h40C; v.hwdata = 32'hDEAD_BEEF; v.e_gnt = 1;
    v.e_maddr = 14'h103; v.e_bwe = 4'hF; v.e_im_valid = 0; v.e_data = 0; vecs.push_back(v);
    v = idle; v.hreq = 1; v.haddr = 32'h40C; v.e_gnt = 1; v.e_maddr = 14'h103;
    v.e_im_valid = 0; v.e_rvalid = 1; v.e_data = 32'hDEAD_BEEF; vecs.push_back(v);
    // store and load together: store wins
    v = idle; v.store = 1; v.load = 1; v.dm_addr = 32'h10; v.dm_wdata = 32'h55; v.sel = 4'hF;
    v.e_ready = 1; v.e_maddr = 14'h4; v.e_bwe = 4'hF; v.e_im_valid = 0; v.e_store_done = 1;
    v.e_data = 0; vecs.push_back(v);
    // host and load together with empty burst count: host wins
    v = idle; v.hreq = 1; v.haddr = 32'h4; v.load = 1; v.dm_addr = 32'h204; v.e_gnt = 1;
    v.e_maddr = 14'h1; v.e_im_valid = 0; v.e_rvalid = 1; v.e_data = 32'h1000_0001;
    vecs.push_back(v);
    // upper address bits wrap: 0x10204 -> word 0x81
    v = idle; v.load = 1; v.dm_addr = 32'h0001_0204; v.e_ready = 1; v.e_maddr = 14'h81;
    v.e_im_valid = 0; v.e_load_done = 1; v.e_data = 32'h1000_0081; vecs.push_back(v);
    v = idle; v.load = 1; v.dm_addr = 32'h10; v.e_ready = 1; v.e_maddr = 14'h4;
    v.e_im_valid = 0; v.e_load_done = 1; v.e_data = 32'h55; vecs.push_back(v);
    v = idle; v.im_addr = 32'h10; v.e_maddr = 14'h4; v.e_data = 32'h55; vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] prev_k;
    logic        prev_g, prev_d, exp_g, exp_d;
    int          hk;

    build_vectors();
    rst = 1; ram_init = 1; im_addr = 32'h100;
    idle_inputs();
    h_req = 1; dm_load = 1; dm_addr = 32'h204; dm_store = 0;
    next_cycle();
    ram_init = 0;
    next_cycle();
    // during reset: nothing granted, no pulses
    chk("rst_gnt", 32'(h_gnt), 0);
    chk("rst_ready", 32'(dm_ready), 0);
    chk("rst_bwe", 32'(m_bwe), 0);
    chk("rst_pulses", {28'h0, im_valid, load_done, store_done, h_rvalid}, 0);
    chk("rst_im_data", im_data, 0);

    // idle CPU fetching 0x100
    idle_inputs(); rst = 0;
    #1 chk("boot_im_valid_c1", 32'(im_valid), 0);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      chk("boot_im_valid", 32'(im_valid), 1);
      chk("boot_im_data", im_data, 32'h13);
    end
    next_cycle();

    // table of single transactions: issue cycle, then response cycle with idle inputs
    foreach (vecs[i]) begin
      dm_load = vecs[i].load; dm_store = vecs[i].store; dm_addr = vecs[i].dm_addr;
      dm_wdata = vecs[i].dm_wdata; dm_sel = vecs[i].sel; h_req = vecs[i].hreq;
      h_we = vecs[i].hwe; h_addr = vecs[i].haddr; h_wdata = vecs[i].hwdata;
      im_addr = vecs[i].im_addr;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(dm_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_gnt", i), 32'(h_gnt), 32'(vecs[i].e_gnt));
      chk($sformatf("v%0d_maddr", i), 32'(m_addr), 32'(vecs[i].e_maddr));
      chk($sformatf("v%0d_bwe", i), 32'(m_bwe), 32'(vecs[i].e_bwe));
      next_cycle();
      idle_inputs();
      #1;
      chk($sformatf("v%0d_im_valid", i), 32'(im_valid), 32'(vecs[i].e_im_valid));
      chk($sformatf("v%0d_load_done", i), 32'(load_done), 32'(vecs[i].e_load_done));
      chk($sformatf("v%0d_store_done", i), 32'(store_done), 32'(vecs[i].e_store_done));
      chk($sformatf("v%0d_rvalid", i), 32'(h_rvalid), 32'(vecs[i].e_rvalid));
      if (vecs[i].e_im_valid) chk($sformatf("v%0d_im_data", i), im_data, vecs[i].e_data);
      if (vecs[i].e_load_done) chk($sformatf("v%0d_ld_data", i), dm_rdata, vecs[i].e_data);
      if (vecs[i].e_rvalid) chk($sformatf("v%0d_h_rdata", i), h_rdata, vecs[i].e_data);
      next_cycle();
    end

    // host streams 10 reads while the CPU holds a load: 4 grants, 1 load, 6 grants
    im_addr = 32'h100; hk = 0; prev_g = 0; prev_d = 0; prev_k = 0;
    for (int c = 0; c < 12; c++) begin
      exp_g = (c < 4) || (c >= 5 && c < 11);
      exp_d = (c == 4);
      h_req = (hk < 10); h_we = 0; h_addr = 32'h800 + 32'(hk) * 4;
      dm_load = (c <= 4); dm_addr = 32'h204;
      #1;
      chk($sformatf("burst%0d_gnt", c), 32'(h_gnt), 32'(exp_g));
      chk($sformatf("burst%0d_ready", c), 32'(dm_ready), 32'(exp_d));
      chk($sformatf("burst%0d_rvalid", c), 32'(h_rvalid), 32'(prev_g));
      chk($sformatf("burst%0d_ld_done", c), 32'(load_done), 32'(prev_d));
      if (prev_g) chk($sformatf("burst%0d_rdata", c), h_rdata, 32'h1000_0200 + prev_k);
      if (prev_d) chk($sformatf("burst%0d_ld_data", c), dm_rdata, 32'h1000_0081);
      prev_g = exp_g; prev_d = exp_d; prev_k = 32'(hk);
      if (exp_g) hk++;
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // branch under an in-flight fetch
    im_addr = 32'h10;
    next_cycle();
    im_addr = 32'h40;
    #1 chk("branch_im_valid_stale", 32'(im_valid), 0);
    next_cycle();
    chk("branch_im_valid", 32'(im_valid), 1);
    chk("branch_im_data", im_data, 32'h1000_0010);
    im_addr = 32'h100;

    // store and load together: the load is accepted in the following cycle
    dm_store = 1; dm_load = 1; dm_addr = 32'h10; dm_wdata = 32'h77; dm_sel = 4'hF;
    #1;
    chk("sl_c0_ready", 32'(dm_ready), 1);
    chk("sl_c0_bwe", 32'(m_bwe), 32'hF);
    next_cycle();
    dm_store = 0; dm_addr = 32'h204;
    #1;
    chk("sl_c1_store_done", 32'(store_done), 1);
    chk("sl_c1_ready", 32'(dm_ready), 1);
    chk("sl_c1_maddr", 32'(m_addr), 32'h81);
    chk("sl_c1_bwe", 32'(m_bwe), 0);
    next_cycle();
    idle_inputs();
    #1;
    chk("sl_c2_load_done", 32'(load_done), 1);
    chk("sl_c2_ld_data", dm_rdata, 32'h1000_0081);
    next_cycle();

    // reset asserted the cycle after a host read grant
    h_req = 1; h_addr = 32'h4;
    #1 chk("rr_gnt", 32'(h_gnt), 1);
    next_cycle();
    rst = 1; dm_load = 1; dm_addr = 32'h204;
    #1;
    chk("rr_rvalid", 32'(h_rvalid), 0);
    chk("rr_pulses", {29'h0, im_valid, load_done, store_done}, 0);
    chk("rr_gnt_rst", 32'(h_gnt), 0);
    chk("rr_ready_rst", 32'(dm_ready), 0);
    chk("rr_bwe_rst", 32'(m_bwe), 0);
    next_cycle();
    idle_inputs(); rst = 0;
    #1 chk("rr_after_rvalid", 32'(h_rvalid), 0);
    next_cycle();
    chk("rr_after_im_valid", 32'(im_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule
